// File: rtl/hazard_ctrl_if.sv
// Hazard/stall controller bus: ID/EXE/MEM hazard sources in, stall/flush/freeze
// controls and performance counters out.
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       Src1_ID;
    logic [4:0]       Src2_ID;
    logic             Two_Src_ID;
    logic [4:0]       Dst_EXE;
    logic             WB_EN_EXE;
    logic             MEM_R_EN_EXE;
    logic [4:0]       Dst_MEM;
    logic             WB_EN_MEM;
    logic             Fwd_EN;
    logic             Br_Taken;
    logic             Mem_Req;
    logic             Mem_Ready;
    logic             Cnt_Clr;
    logic             Hazard_Stall;
    logic             Flush_IF_ID;
    logic             Flush_ID_EXE;
    logic             Pipe_Freeze;
    logic             Mem_Err;
    logic [CNT_W-1:0] Stall_Count;
    logic [CNT_W-1:0] Freeze_Count;

    // Level-based controls, no valid/ready pairing: every output is meaningful
    // each cycle and the pipeline samples it at the same rising edge.
    modport master (
        output Src1_ID, Src2_ID, Two_Src_ID, Dst_EXE, WB_EN_EXE, MEM_R_EN_EXE,
               Dst_MEM, WB_EN_MEM, Fwd_EN, Br_Taken, Mem_Req, Mem_Ready, Cnt_Clr,
        input  Hazard_Stall, Flush_IF_ID, Flush_ID_EXE, Pipe_Freeze, Mem_Err,
               Stall_Count, Freeze_Count
    );

    modport slave (
        input  Src1_ID, Src2_ID, Two_Src_ID, Dst_EXE, WB_EN_EXE, MEM_R_EN_EXE,
               Dst_MEM, WB_EN_MEM, Fwd_EN, Br_Taken, Mem_Req, Mem_Ready, Cnt_Clr,
        output Hazard_Stall, Flush_IF_ID, Flush_ID_EXE, Pipe_Freeze, Mem_Err,
               Stall_Count, Freeze_Count
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Load-use / non-forwardable RAW stall, branch flush, data-memory freeze FSM with
// timeout, and saturating stall/freeze counters for the 5-stage MIPS pipeline.
module hazard_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave hz,
    output logic [1:0]   fsm_state
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

    state_t           state, state_nxt;
    logic [15:0]      wait_cnt, wait_cnt_nxt;
    logic [CNT_W-1:0] stall_cnt, freeze_cnt;
    logic             src_exe, src_mem, raw_hazard;
    logic             freeze, stall, flush;

    function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
        return (a == b) && (a != 5'd0);
    endfunction

    always_comb begin
        src_exe = reg_match(hz.Src1_ID, hz.Dst_EXE) ||
                  (hz.Two_Src_ID && reg_match(hz.Src2_ID, hz.Dst_EXE));
        src_mem = reg_match(hz.Src1_ID, hz.Dst_MEM) ||
                  (hz.Two_Src_ID && reg_match(hz.Src2_ID, hz.Dst_MEM));
        // WB writers never stall: the register file is write-first.
        if (hz.Fwd_EN)
            raw_hazard = src_exe && hz.MEM_R_EN_EXE;
        else
            raw_hazard = (src_exe && hz.WB_EN_EXE) || (src_mem && hz.WB_EN_MEM);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RUN;
            wait_cnt <= 16'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        freeze       = 1'b0;
        case (state)
            RUN: begin
                freeze = hz.Mem_Req && !hz.Mem_Ready;
                if (freeze) begin
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = 16'd1;
                end
            end
            MEM_WAIT: begin
                // Once waiting, only Mem_Ready ends it; Mem_Req is ignored.
                freeze = !hz.Mem_Ready;
                if (hz.Mem_Ready)
                    state_nxt = RUN;
                else if (wait_cnt == TIMEOUT_C)
                    state_nxt = ERROR;
                else
                    wait_cnt_nxt = wait_cnt + 16'd1;
            end
            ERROR:   freeze = 1'b1;
            default: state_nxt = RUN;
        endcase
        if (!rst)
            freeze = 1'b0;
    end

    // A freeze suppresses flush and stall; the held instructions are re-judged afterwards.
    always_comb begin
        stall = 1'b0;
        flush = 1'b0;
        if (rst && !freeze) begin
            if (hz.Br_Taken)
                flush = 1'b1;
            else
                stall = raw_hazard;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt  <= '0;
            freeze_cnt <= '0;
        end else if (hz.Cnt_Clr) begin
            stall_cnt  <= '0;
            freeze_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (freeze && (freeze_cnt != '1))
                freeze_cnt <= freeze_cnt + CNT_W'(1);
        end
    end

    assign hz.Hazard_Stall = stall;
    assign hz.Flush_IF_ID  = flush;
    assign hz.Flush_ID_EXE = flush;
    assign hz.Pipe_Freeze  = freeze;
    assign hz.Mem_Err      = rst && (state == ERROR);
    assign hz.Stall_Count  = stall_cnt;
    assign hz.Freeze_Count = freeze_cnt;
    assign fsm_state       = state;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed and randomized bench for hazard_ctrl against a cycle-level reference
// model of the stall, flush, freeze/timeout and counter rules.
module tb_hazard_ctrl;
    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] fsm_state;

    hazard_ctrl_if #(.CNT_W(CNT_W)) hif ();

    hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .hz        (hif),
        .fsm_state (fsm_state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: error flag, length of the current freeze episode, counters.
    bit               m_err;
    int               m_len;
    int               m_stall_cnt;
    int               m_freeze_cnt;
    logic [CNT_W-1:0] exp_q[$];

    task automatic model_reset();
        m_err        = 1'b0;
        m_len        = 0;
        m_stall_cnt  = 0;
        m_freeze_cnt = 0;
        exp_q.delete();
        exp_q.push_back('0);
        exp_q.push_back('0);
    endtask

    function automatic logic mt(input logic [4:0] a, input logic [4:0] b);
        return (a == b) && (a != 5'd0);
    endfunction

    function automatic logic ref_raw();
        logic hit_exe, hit_mem;
        hit_exe = mt(hif.Src1_ID, hif.Dst_EXE) || (hif.Two_Src_ID && mt(hif.Src2_ID, hif.Dst_EXE));
        hit_mem = mt(hif.Src1_ID, hif.Dst_MEM) || (hif.Two_Src_ID && mt(hif.Src2_ID, hif.Dst_MEM));
        if (hif.Fwd_EN) return hit_exe && hif.MEM_R_EN_EXE;
        return (hit_exe && hif.WB_EN_EXE) || (hit_mem && hif.WB_EN_MEM);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic set_idle();
        hif.Src1_ID = 5'd0; hif.Src2_ID = 5'd0; hif.Two_Src_ID = 1'b0;
        hif.Dst_EXE = 5'd0; hif.WB_EN_EXE = 1'b0; hif.MEM_R_EN_EXE = 1'b0;
        hif.Dst_MEM = 5'd0; hif.WB_EN_MEM = 1'b0; hif.Fwd_EN = 1'b1;
        hif.Br_Taken = 1'b0; hif.Mem_Req = 1'b0; hif.Mem_Ready = 1'b0; hif.Cnt_Clr = 1'b0;
    endtask

    task automatic set_load_use();
        hif.Fwd_EN = 1'b1; hif.MEM_R_EN_EXE = 1'b1; hif.WB_EN_EXE = 1'b1;
        hif.Dst_EXE = 5'd8; hif.Src1_ID = 5'd8;
    endtask

    task automatic set_random();
        hif.Src1_ID      = 5'($urandom_range(0, 3));
        hif.Src2_ID      = 5'($urandom_range(0, 3));
        hif.Two_Src_ID   = 1'($urandom_range(0, 1));
        hif.Dst_EXE      = 5'($urandom_range(0, 3));
        hif.WB_EN_EXE    = 1'($urandom_range(0, 1));
        hif.MEM_R_EN_EXE = 1'($urandom_range(0, 1));
        hif.Dst_MEM      = 5'($urandom_range(0, 3));
        hif.WB_EN_MEM    = 1'($urandom_range(0, 1));
        hif.Fwd_EN       = 1'($urandom_range(0, 1));
        hif.Br_Taken     = ($urandom_range(0, 4) == 0);
        hif.Mem_Req      = 1'($urandom_range(0, 1));
        hif.Mem_Ready    = ($urandom_range(0, 3) != 0);
        hif.Cnt_Clr      = ($urandom_range(0, 7) == 0);
    endtask

    // One cycle: check outputs at the falling edge, advance the model, return after the rising edge.
    task automatic step(input string tag);
        logic             e_freeze, e_stall, e_flush, e_err;
        logic [1:0]       e_state;
        logic [CNT_W-1:0] e_sc, e_fc;
        @(negedge clk);
        if (!rst) model_reset();
        if (!rst) begin
            e_freeze = 1'b0; e_stall = 1'b0; e_flush = 1'b0; e_err = 1'b0; e_state = 2'd0;
        end else begin
            if (m_err)        e_freeze = 1'b1;
            else if (m_len > 0) e_freeze = !hif.Mem_Ready;
            else              e_freeze = hif.Mem_Req && !hif.Mem_Ready;
            e_flush = !e_freeze && hif.Br_Taken;
            e_stall = !e_freeze && !hif.Br_Taken && ref_raw();
            e_err   = m_err;
            e_state = m_err ? 2'd2 : ((m_len > 0) ? 2'd1 : 2'd0);
        end
        e_sc = exp_q.pop_front();
        e_fc = exp_q.pop_front();
        chk({tag, "/stall"},   32'(hif.Hazard_Stall), 32'(e_stall));
        chk({tag, "/fl_ifid"}, 32'(hif.Flush_IF_ID),  32'(e_flush));
        chk({tag, "/fl_idex"}, 32'(hif.Flush_ID_EXE), 32'(e_flush));
        chk({tag, "/freeze"},  32'(hif.Pipe_Freeze),  32'(e_freeze));
        chk({tag, "/mem_err"}, 32'(hif.Mem_Err),      32'(e_err));
        chk({tag, "/state"},   32'(fsm_state),        32'(e_state));
        chk({tag, "/st_cnt"},  32'(hif.Stall_Count),  32'(e_sc));
        chk({tag, "/fz_cnt"},  32'(hif.Freeze_Count), 32'(e_fc));
        if (!rst) begin
            model_reset();
        end else begin
            if (hif.Cnt_Clr) begin
                m_stall_cnt = 0; m_freeze_cnt = 0;
            end else begin
                if (e_stall  && m_stall_cnt  < CNT_MAX) m_stall_cnt++;
                if (e_freeze && m_freeze_cnt < CNT_MAX) m_freeze_cnt++;
            end
            if (!m_err) begin
                if (e_freeze) begin
                    m_len++;
                    if (m_len > TIMEOUT) begin
                        m_err = 1'b1;
                        m_len = 0;
                    end
                end else begin
                    m_len = 0;
                end
            end
            exp_q.push_back(CNT_W'(m_stall_cnt));
            exp_q.push_back(CNT_W'(m_freeze_cnt));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        model_reset();
        set_idle();
        // Reset holds every output low whatever the inputs say.
        set_load_use();
        hif.Mem_Req = 1'b1; hif.Br_Taken = 1'b1;
        step("rst_hold");
        rst = 1'b1;
        set_idle();
        hif.Cnt_Clr = 1'b1;
        step("clr");

        // Load-use with forwarding: one stall cycle, counted next cycle.
        set_idle();
        set_load_use();
        step("load_use");
        set_idle();
        chk("lu_count", 32'(hif.Stall_Count), 32'd1);
        step("lu_after");

        // No-forward mode.
        hif.Fwd_EN = 1'b0; hif.WB_EN_EXE = 1'b1; hif.Dst_EXE = 5'd5;
        hif.Src2_ID = 5'd5; hif.Two_Src_ID = 1'b0;
        step("nf_one_src");
        hif.Two_Src_ID = 1'b1;
        step("nf_two_src");
        hif.Dst_EXE = 5'd0; hif.Src2_ID = 5'd0;
        step("nf_reg0");
        set_idle();
        hif.Fwd_EN = 1'b0; hif.WB_EN_MEM = 1'b1; hif.Dst_MEM = 5'd7; hif.Src1_ID = 5'd7;
        step("nf_mem");
        hif.Fwd_EN = 1'b1;
        step("fwd_mem");

        // Branch beats a load-use stall.
        set_idle();
        set_load_use();
        hif.Br_Taken = 1'b1;
        step("br_lu");

        // Three-cycle memory wait; a branch during the freeze must not flush.
        set_idle();
        hif.Cnt_Clr = 1'b1;
        step("clr2");
        hif.Cnt_Clr = 1'b0;
        hif.Mem_Req = 1'b1;
        step("mw1");
        hif.Br_Taken = 1'b1; hif.Mem_Req = 1'b0;
        step("mw2_br");
        hif.Br_Taken = 1'b0;
        step("mw3");
        hif.Mem_Ready = 1'b1;
        step("mw_ready");
        set_idle();
        chk("fz_count3", 32'(hif.Freeze_Count), 32'd3);
        step("mw_after");

        // Timeout into the error state, then reset out of it.
        hif.Mem_Req = 1'b1; hif.Mem_Ready = 1'b0;
        for (int i = 0; i < 7; i++) step("timeout");
        chk("to_state", 32'(fsm_state), 32'd2);
        chk("to_err", 32'(hif.Mem_Err), 32'd1);
        hif.Mem_Ready = 1'b1; hif.Mem_Req = 1'b0;
        set_load_use();
        step("err_hold");
        rst = 1'b0;
        step("err_rst");
        rst = 1'b1;
        set_idle();
        step("post_rst");

        // Stall counter saturation and clear-over-increment.
        set_load_use();
        for (int i = 0; i < 20; i++) step("sat");
        chk("sat_count", 32'(hif.Stall_Count), 32'(CNT_MAX));
        hif.Cnt_Clr = 1'b1;
        step("sat_clr");
        chk("clr_zero", 32'(hif.Stall_Count), 32'd0);
        hif.Cnt_Clr = 1'b0;

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            set_random();
            rst = ($urandom_range(0, 59) != 0);
            step("rand");
        end
        rst = 1'b1;
        set_idle();
        step("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
